// File: rtl/systolic_pkg.sv
// Shared constants and types for the 2x2 systolic matrix multiplier.
package systolic_pkg;

    localparam int DEF_DATA_WIDTH = 4;
    localparam int DEF_ACC_WIDTH  = 9;

    function automatic int prod_width(input int dw);
        return 2 * dw;
    endfunction

    localparam int PROD_WIDTH = prod_width(DEF_DATA_WIDTH);

    typedef enum logic {
        PH_EVEN = 1'b0,
        PH_ODD  = 1'b1
    } phase_t;

endpackage

// File: rtl/systolic_array_2x2_if.sv
// Element bus between the skewing front-end, the array and the result consumer.
interface systolic_array_2x2_if
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
);

    logic                  in_valid;
    logic [DATA_WIDTH-1:0] a00, a01, a10, a11;
    logic [DATA_WIDTH-1:0] b00, b01, b10, b11;
    logic                  out_valid;
    logic [ACC_WIDTH-1:0]  c00, c01, c10, c11;

    modport master (
        output in_valid, a00, a01, a10, a11, b00, b01, b10, b11,
        input  out_valid, c00, c01, c10, c11
    );

    modport slave (
        input  in_valid, a00, a01, a10, a11, b00, b01, b10, b11,
        output out_valid, c00, c01, c10, c11
    );

endinterface

// File: rtl/systolic_pe.sv
// Registered multiply-accumulate cell: load starts a new partial sum, accum adds onto it.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load,
    input  logic                  accum,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] w,
    output logic [ACC_WIDTH-1:0]  acc
);

    localparam int PW = prod_width(DATA_WIDTH);

    logic [PW-1:0]        prod;
    logic [ACC_WIDTH-1:0] prod_ext;

    assign prod     = PW'(a) * PW'(w);
    assign prod_ext = ACC_WIDTH'(prod);

    always_ff @(posedge clk) begin
        if (rstn) begin
            acc <= '0;
        end else if (load) begin
            acc <= prod_ext;
        end else if (accum) begin
            acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/systolic_array_2x2.sv
// Streaming 2x2 unsigned matrix multiplier; sets start every even sample and each
// set parity owns a private bank of weights and partial sums.
module systolic_array_2x2
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int LSIZE      = 2,
    parameter int RSIZE      = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    systolic_array_2x2_if.slave  bus
);

    if (LSIZE != 2 || RSIZE != 2 || ACC_WIDTH < prod_width(DATA_WIDTH) + 1) begin : g_bad_cfg
        $error("systolic_array_2x2: unsupported configuration");
    end

    // cnt[0] is the phase; cnt[1] is the parity of the set whose t0 is this pair.
    logic [1:0] cnt;
    logic       warm;
    phase_t     phase;
    logic       grp;
    logic       even;
    logic       odd;

    assign phase = phase_t'(cnt[0]);
    assign grp   = cnt[1];
    assign even  = (phase == PH_EVEN);
    assign odd   = (phase == PH_ODD);

    logic [DATA_WIDTH-1:0] w_b00 [2];
    logic [DATA_WIDTH-1:0] w_b01 [2];
    logic [DATA_WIDTH-1:0] w_b10 [2];
    logic [DATA_WIDTH-1:0] w_b11 [2];
    logic [ACC_WIDTH-1:0]  acc00 [2];
    logic [ACC_WIDTH-1:0]  acc01 [2];
    logic [ACC_WIDTH-1:0]  acc10 [2];
    logic [ACC_WIDTH-1:0]  acc11 [2];
    logic                  vld_p0 [2];
    logic                  vld_p1;

    always_ff @(posedge clk) begin
        if (rstn) begin
            cnt  <= '0;
            warm <= 1'b0;
        end else begin
            cnt  <= cnt + 2'd1;
            warm <= 1'b1;
        end
    end

    // Stage p0: weight capture on schedule, independent of in_valid.
    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int q = 0; q < 2; q++) begin
                w_b00[q] <= '0;
                w_b01[q] <= '0;
                w_b10[q] <= '0;
                w_b11[q] <= '0;
            end
        end else if (even) begin
            w_b01[grp]  <= bus.b01;
            w_b11[~grp] <= bus.b11;
        end else begin
            w_b00[grp]  <= bus.b00;
            w_b10[grp]  <= bus.b10;
        end
    end

    // Stage p1: per-set validity over the three A-sample edges; warm drops the phantom set before sample 0.
    always_ff @(posedge clk) begin
        if (rstn) begin
            vld_p0[0] <= 1'b0;
            vld_p0[1] <= 1'b0;
            vld_p1    <= 1'b0;
        end else if (even) begin
            vld_p0[~grp] <= bus.in_valid & warm;
            vld_p1       <= vld_p0[grp] & bus.in_valid;
        end else begin
            vld_p0[~grp] <= vld_p0[~grp] & bus.in_valid;
        end
    end

    for (genvar q = 0; q < 2; q++) begin : g_set
        localparam logic SETQ = 1'(q);
        logic pre;
        logic post;

        // pre: this bank is in its a00/a01/a10 window; post: its a11 edge.
        assign pre  = (grp != SETQ);
        assign post = (grp == SETQ);

        systolic_pe #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) pe00 (
            .clk(clk), .rstn(rstn), .load(even & pre), .accum(odd & pre),
            .a(odd ? bus.a01 : bus.a00), .w(odd ? w_b10[q] : w_b00[q]), .acc(acc00[q])
        );
        systolic_pe #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) pe01 (
            .clk(clk), .rstn(rstn), .load(even & pre), .accum(odd & pre),
            .a(odd ? bus.a01 : bus.a00), .w(odd ? w_b11[q] : w_b01[q]), .acc(acc01[q])
        );
        systolic_pe #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) pe10 (
            .clk(clk), .rstn(rstn), .load(odd & pre), .accum(even & post),
            .a(odd ? bus.a10 : bus.a11), .w(odd ? w_b00[q] : w_b10[q]), .acc(acc10[q])
        );
        systolic_pe #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) pe11 (
            .clk(clk), .rstn(rstn), .load(odd & pre), .accum(even & post),
            .a(odd ? bus.a10 : bus.a11), .w(odd ? w_b01[q] : w_b11[q]), .acc(acc11[q])
        );
    end

    // Stage p2: result registers update only on odd edges, holding through the next even one.
    always_ff @(posedge clk) begin
        if (rstn) begin
            bus.out_valid <= 1'b0;
            bus.c00       <= '0;
            bus.c01       <= '0;
            bus.c10       <= '0;
            bus.c11       <= '0;
        end else if (odd) begin
            bus.out_valid <= vld_p1;
            if (vld_p1) begin
                bus.c00 <= acc00[grp];
                bus.c01 <= acc01[grp];
                bus.c10 <= acc10[grp];
                bus.c11 <= acc11[grp];
            end
        end
    end

endmodule

// File: tb/tb_systolic_array_2x2.sv
// Randomized bench for systolic_array_2x2 against a matrix-level reference model.
module tb_systolic_array_2x2;

    localparam int DW   = 4;
    localparam int AW   = 9;
    localparam int MAXN = 32;
    localparam int MAXS = 2 * MAXN + 8;

    logic clk;
    logic rstn;

    systolic_array_2x2_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus ();

    systolic_array_2x2 #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_err;

    // Matrices per set, in_valid per sample, and the per-sample port tables.
    int ma [MAXN][2][2];
    int mb [MAXN][2][2];
    bit ivt [MAXS];
    int pa [MAXS][2][2];
    int pb [MAXS][2][2];

    int exp_c [2][2];
    bit exp_v;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int cval(input int n, input int i, input int j);
        return ma[n][i][0] * mb[n][0][j] + ma[n][i][1] * mb[n][1][j];
    endfunction

    task automatic check_out(input string where);
        chk({"out_valid@", where}, 32'(bus.out_valid), 32'(exp_v));
        chk({"c00@", where}, 32'(bus.c00), exp_c[0][0]);
        chk({"c01@", where}, 32'(bus.c01), exp_c[0][1]);
        chk({"c10@", where}, 32'(bus.c10), exp_c[1][0]);
        chk({"c11@", where}, 32'(bus.c11), exp_c[1][1]);
    endtask

    task automatic clear_model();
        exp_v = 1'b0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                exp_c[i][j] = 0;
    endtask

    task automatic rand_inputs();
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.a00 = DW'($urandom); bus.a01 = DW'($urandom);
        bus.a10 = DW'($urandom); bus.a11 = DW'($urandom);
        bus.b00 = DW'($urandom); bus.b01 = DW'($urandom);
        bus.b10 = DW'($urandom); bus.b11 = DW'($urandom);
    endtask

    task automatic do_reset(input string tag);
        rstn = 1'b1;
        rand_inputs();
        repeat (2) @(posedge clk);
        #1;
        clear_model();
        check_out(tag);
        rstn = 1'b0;
    endtask

    task automatic set_ab(input int n, input int a00, input int a01, input int a10, input int a11,
                          input int b00, input int b01, input int b10, input int b11);
        ma[n][0][0] = a00; ma[n][0][1] = a01; ma[n][1][0] = a10; ma[n][1][1] = a11;
        mb[n][0][0] = b00; mb[n][0][1] = b01; mb[n][1][0] = b10; mb[n][1][1] = b11;
    endtask

    task automatic rand_sets(input int first, input int last);
        for (int n = first; n <= last; n++)
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++) begin
                    ma[n][i][j] = int'($urandom_range(0, 15));
                    mb[n][i][j] = int'($urandom_range(0, 15));
                end
    endtask

    // Sample 0 is the first edge of this task; abort_at >= 0 resets on that sample instead.
    task automatic run_block(input string name, input int nsets, input int abort_at);
        int last;
        int t0;
        int n;
        last = 2 * nsets + 4;
        for (int s = 0; s <= last; s++)
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++) begin
                    pa[s][i][j] = int'($urandom_range(0, 15));
                    pb[s][i][j] = int'($urandom_range(0, 15));
                end
        for (int k = 0; k < nsets; k++) begin
            t0 = 2 * k;
            pb[t0][0][1]     = mb[k][0][1];
            pb[t0 + 1][0][0] = mb[k][0][0];
            pb[t0 + 1][1][0] = mb[k][1][0];
            pb[t0 + 2][1][1] = mb[k][1][1];
            pa[t0 + 2][0][0] = ma[k][0][0];
            pa[t0 + 3][0][1] = ma[k][0][1];
            pa[t0 + 3][1][0] = ma[k][1][0];
            pa[t0 + 4][1][1] = ma[k][1][1];
        end
        for (int s = 0; s <= last; s++) begin
            bus.in_valid = ivt[s];
            bus.a00 = DW'(pa[s][0][0]); bus.a01 = DW'(pa[s][0][1]);
            bus.a10 = DW'(pa[s][1][0]); bus.a11 = DW'(pa[s][1][1]);
            bus.b00 = DW'(pb[s][0][0]); bus.b01 = DW'(pb[s][0][1]);
            bus.b10 = DW'(pb[s][1][0]); bus.b11 = DW'(pb[s][1][1]);
            rstn = (s == abort_at);
            @(posedge clk);
            #1;
            if (s == abort_at) begin
                clear_model();
                check_out($sformatf("%s/abort%0d", name, s));
                rstn = 1'b0;
                return;
            end
            if ((s % 2 == 1) && s >= 5) begin
                n = (s - 5) / 2;
                if (n < nsets) begin
                    exp_v = ivt[2 * n + 2] & ivt[2 * n + 3] & ivt[2 * n + 4];
                    if (exp_v)
                        for (int i = 0; i < 2; i++)
                            for (int j = 0; j < 2; j++)
                                exp_c[i][j] = cval(n, i, j);
                end
            end
            check_out($sformatf("%s/e%0d", name, s));
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rstn  = 1'b1;
        clear_model();
        do_reset("reset0");

        // Directed: plan sets, in_valid drop at 10, all-max set, single drop at t0+3 of set 6.
        set_ab(0, 4, 3, 12, 4, 4, 2, 6, 8);
        set_ab(1, 12, 14, 10, 1, 7, 4, 8, 1);
        set_ab(2, 2, 3, 4, 9, 3, 1, 5, 7);
        rand_sets(3, 4);
        set_ab(5, 15, 15, 15, 15, 15, 15, 15, 15);
        rand_sets(6, 8);
        for (int s = 0; s < MAXS; s++) ivt[s] = 1'b1;
        ivt[0]  = 1'b0;
        ivt[1]  = 1'b0;
        ivt[10] = 1'b0;
        ivt[15] = 1'b0;
        run_block("dir", 9, -1);

        do_reset("reset1");

        // Reset at t0+3 of set 2, then a fresh run straight after release.
        rand_sets(0, 5);
        for (int s = 0; s < MAXS; s++) ivt[s] = 1'b1;
        run_block("abort", 6, 7);
        rand_sets(0, 3);
        run_block("fresh", 4, -1);

        for (int r = 0; r < 4; r++) begin
            do_reset($sformatf("reset_r%0d", r));
            rand_sets(0, 11);
            for (int s = 0; s < MAXS; s++) ivt[s] = ($urandom_range(0, 5) != 0);
            run_block($sformatf("rnd%0d", r), 12, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
